// File: rtl/mpi_dma_master.sv
// mpi_dma_master: DMA bus-master sequencer for the 1801VM1 MPI bus.
// It requests the bus from the CPU (dmr_n / dmgi_n), takes it with sack_n,
// and runs single or burst DATI / DATO / DATOB cycles on the inverted ad_n bus.
// It then returns the bus to the CPU.
//
// Ports
//   clk, rst_n          bus clock, asynchronous active-low reset
//   req, we, byte_en    local command request: write select and byte-write select
//   addr, wdata         byte address and write data of the command
//   ack, err            one-cycle completion pulse; err flags an RPLY timeout
//   rdata               read data, updated only on a successful read
//   busy                high from command acceptance until the bus is released
//   init_n              bus INIT; aborts the current tenure, issues no ack
//   dmgi_n, dmr_n       DMA grant in / DMA request out
//   sack_n              select acknowledge (bus ownership)
//   sync_n_i, rply_n_i  sampled bus SYNC / RPLY
//   sync_n, din_n,      bus strobes driven while this block is master
//   dout_n, wtbt_n
//   ad_n_i, ad_n_o,     sampled ad_n bus, driven ad_n value and its output enable
//   ad_oe
module mpi_dma_master #(
  parameter int SETUP     = 2,
  parameter int TIMEOUT   = 64,
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic        byte_en,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  input  logic        init_n,
  input  logic        dmgi_n,
  output logic        dmr_n,
  output logic        sack_n,
  input  logic        sync_n_i,
  input  logic        rply_n_i,
  output logic        sync_n,
  output logic        din_n,
  output logic        dout_n,
  output logic        wtbt_n,
  input  logic [15:0] ad_n_i,
  output logic [15:0] ad_n_o,
  output logic        ad_oe
);

  localparam int CW = $clog2(TIMEOUT + SETUP + 1) + 1;
  localparam int BW = $clog2(BURST_MAX + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAITBUS, S_ADDR, S_DATA, S_RPLY, S_END
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  burst_cnt;
  logic           to_q;
  logic           dmgi_q;

  logic           we_q;
  logic           byte_q;
  logic [15:0]    addr_q;
  logic [15:0]    wdata_q;

  logic           end_done;
  logic           burst_go;
  logic           load_cmd;

  // END completes once the slave drops RPLY, or immediately after a timeout.
  assign end_done = to_q | rply_n_i;
  // Another transfer may follow under the same grant only without an error
  // and while the burst budget is not used up.
  assign burst_go = req & ~to_q & (burst_cnt != BW'(BURST_MAX - 1));
  assign load_cmd = init_n & (((state == S_IDLE) & req) |
                              ((state == S_END) & end_done & burst_go));

  // Command latch: pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (load_cmd) begin
      we_q    <= we;
      byte_q  <= byte_en;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      burst_cnt <= '0;
      to_q      <= 1'b0;
      dmgi_q    <= 1'b1;
      dmr_n     <= 1'b1;
      sack_n    <= 1'b1;
      sync_n    <= 1'b1;
      din_n     <= 1'b1;
      dout_n    <= 1'b1;
      wtbt_n    <= 1'b1;
      ad_oe     <= 1'b0;
      ad_n_o    <= 16'hFFFF;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= 16'h0000;
    end else if (!init_n) begin
      // Bus INIT: drop everything back to idle, keep the last read data.
      state     <= S_IDLE;
      cnt       <= '0;
      burst_cnt <= '0;
      to_q      <= 1'b0;
      dmgi_q    <= 1'b1;
      dmr_n     <= 1'b1;
      sack_n    <= 1'b1;
      sync_n    <= 1'b1;
      din_n     <= 1'b1;
      dout_n    <= 1'b1;
      wtbt_n    <= 1'b1;
      ad_oe     <= 1'b0;
      ad_n_o    <= 16'hFFFF;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack    <= 1'b0;
      err    <= 1'b0;
      dmgi_q <= dmgi_n;
      case (state)
        S_IDLE: begin
          if (req) begin
            busy      <= 1'b1;
            dmr_n     <= 1'b0;
            burst_cnt <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          // Take the bus and withdraw the request on the same edge.
          if (!dmgi_q) begin
            sack_n <= 1'b0;
            dmr_n  <= 1'b1;
            state  <= S_WAITBUS;
          end
        end
        S_WAITBUS: begin
          if (sync_n_i && rply_n_i) begin
            ad_oe  <= 1'b1;
            ad_n_o <= ~addr_q;
            wtbt_n <= ~we_q;
            cnt    <= '0;
            to_q   <= 1'b0;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (cnt == CW'(SETUP - 1)) begin
            sync_n <= 1'b0;
            cnt    <= '0;
            state  <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          // The address stays on the bus for one cycle after SYNC falls so
          // the slave latches it; the data phase starts on the next edge.
          if (cnt == '0) begin
            if (we_q) begin
              ad_n_o <= ~wdata_q;
              wtbt_n <= ~byte_q;
            end else begin
              ad_oe  <= 1'b0;
              wtbt_n <= 1'b1;
            end
          end
          if (cnt == CW'(SETUP)) begin
            if (we_q) dout_n <= 1'b0;
            else      din_n  <= 1'b0;
            cnt   <= '0;
            state <= S_RPLY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RPLY: begin
          if (!rply_n_i) begin
            if (!we_q) rdata <= ~ad_n_i;
            din_n  <= 1'b1;
            dout_n <= 1'b1;
            state  <= S_END;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            to_q   <= 1'b1;
            din_n  <= 1'b1;
            dout_n <= 1'b1;
            state  <= S_END;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_END: begin
          if (end_done) begin
            sync_n    <= 1'b1;
            wtbt_n    <= 1'b1;
            ad_oe     <= 1'b0;
            ad_n_o    <= 16'hFFFF;
            ack       <= 1'b1;
            err       <= to_q;
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_go) begin
              // Next burst beat: keep sack_n, present the new address now.
              ad_oe  <= 1'b1;
              ad_n_o <= ~addr;
              wtbt_n <= ~we;
              cnt    <= '0;
              state  <= S_ADDR;
            end else begin
              sack_n <= 1'b1;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_dma_master.sv
module tb_mpi_dma_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        byte_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        ack, err, busy;
  logic [15:0] rdata;
  logic        init_n = 1'b1;
  logic        dmgi_n = 1'b1;
  logic        dmr_n, sack_n;
  logic        sync_n_i;
  logic        rply_n_i = 1'b1;
  logic        sync_n, din_n, dout_n, wtbt_n;
  logic [15:0] ad_n_i, ad_n_o;
  logic        ad_oe;

  logic        ext_sync = 1'b0;

  logic [15:0] mem [0:255];
  logic        sl_sel = 1'b0;
  logic        sl_drv = 1'b0;
  logic [15:0] sl_addr = 16'h0000;
  logic [15:0] sl_ad = 16'hFFFF;
  logic        sl_wtbt_a = 1'b1;
  logic        sl_wtbt_d = 1'b1;
  logic [15:0] sl_w;
  logic        dmr_prev = 1'b1;
  int          gcnt = 0;

  int total = 0;
  int bad = 0;

  mpi_dma_master #(.SETUP(2), .TIMEOUT(64), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .init_n(init_n), .dmgi_n(dmgi_n), .dmr_n(dmr_n),
    .sack_n(sack_n), .sync_n_i(sync_n_i), .rply_n_i(rply_n_i),
    .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n),
    .ad_n_i(ad_n_i), .ad_n_o(ad_n_o), .ad_oe(ad_oe)
  );

  always #5 clk = ~clk;

  // Another master may hold SYNC low; the bus is the master's or the slave's drive.
  assign sync_n_i = sync_n & ~ext_sync;
  assign ad_n_i   = ad_oe ? ad_n_o : (sl_drv ? sl_ad : 16'hFFFF);

  // CPU grant model: answers DMR half a cycle later.
  always @(negedge clk) begin
    dmgi_n = dmr_n;
    if (dmr_prev && !dmr_n) gcnt++;
    dmr_prev = dmr_n;
  end

  // RAM slave below 16'o160000; nothing answers above it.
  always @(negedge clk) begin
    if (sync_n) begin
      sl_sel = 1'b0;
    end else if (!sl_sel) begin
      sl_sel    = 1'b1;
      sl_addr   = ~ad_n_o;
      sl_wtbt_a = wtbt_n;
    end
    if (sl_sel && sl_addr < 16'hE000 && (!din_n || !dout_n)) begin
      if (!din_n) begin
        sl_ad  = ~mem[sl_addr[8:1]];
        sl_drv = 1'b1;
      end else if (rply_n_i) begin
        sl_w      = ~ad_n_o;
        sl_wtbt_d = wtbt_n;
        if (!wtbt_n) begin
          if (sl_addr[0]) mem[sl_addr[8:1]][15:8] = sl_w[15:8];
          else            mem[sl_addr[8:1]][7:0]  = sl_w[7:0];
        end else begin
          mem[sl_addr[8:1]] = sl_w;
        end
      end
      rply_n_i = 1'b0;
    end else begin
      rply_n_i = 1'b1;
      sl_drv   = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic start(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    we = w; byte_en = b; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_ack(input int maxc, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk); #1;
      if (ack) ok = 1'b1;
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    int g0, dcnt, viol, acks;
    logic seen;
    logic [15:0] ba [0:5];

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'o012345;
    for (int i = 0; i < 6; i++) begin
      ba[i] = 16'o001004 + 16'(2 * i);
      mem[2 + i] = 16'h3000 + 16'(i);
    end

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_ctl", {dmr_n, sack_n, sync_n, din_n, dout_n, wtbt_n, ad_oe, ack, err, busy},
        10'b1111110000);
    chk("rst_ad", ad_n_o, 16'hFFFF);
    chk("rst_rdata", rdata, 16'h0000);

    // T1: single read
    start(1'b0, 1'b0, 16'o001000, 16'h0000);
    chk("t1_busy", busy, 1'b1);
    chk("t1_dmr", dmr_n, 1'b0);
    wait_ack(200, "t1_ack");
    chk("t1_rdata", rdata, 16'o012345);
    chk("t1_err", err, 1'b0);
    chk("t1_rel", {sack_n, busy}, 2'b10);

    // T2: byte write to the high byte
    start(1'b1, 1'b1, 16'o001001, 16'hAB00);
    wait_ack(200, "t2_ack");
    chk("t2_err", err, 1'b0);
    chk("t2_mem", mem[0], 16'hABE5);
    chk("t2_wtbt_a", sl_wtbt_a, 1'b0);
    chk("t2_wtbt_d", sl_wtbt_d, 1'b0);

    // Word write then read back
    start(1'b1, 1'b0, 16'o001002, 16'h1234);
    wait_ack(200, "ww_ack");
    chk("ww_mem", mem[1], 16'h1234);
    chk("ww_wtbt", {sl_wtbt_a, sl_wtbt_d}, 2'b01);
    start(1'b0, 1'b0, 16'o001002, 16'h0000);
    wait_ack(200, "wr_ack");
    chk("wr_rdata", rdata, 16'h1234);

    // T3: six reads with req held; four per grant
    g0 = gcnt;
    we = 1'b0; byte_en = 1'b0; addr = ba[0]; req = 1'b1;
    @(posedge clk); #1;
    chk("t3_busy", busy, 1'b1);
    addr = ba[1];
    for (int k = 0; k < 6; k++) begin
      wait_ack(200, "t3_ack");
      chk("t3_rdata", rdata, 16'h3000 + 16'(k));
      chk("t3_err", err, 1'b0);
      if (k < 3) begin
        chk("t3_sack_held", sack_n, 1'b0);
        addr = ba[k + 2];
      end else if (k == 3) begin
        chk("t3_sack_rel", {sack_n, busy}, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
          @(posedge clk); #1;
          if (busy) seen = 1'b1;
        end
        chk("t3_rereq", seen, 1'b1);
        addr = ba[5];
      end else if (k == 4) begin
        chk("t3_sack_held2", sack_n, 1'b0);
        req = 1'b0;
      end else begin
        chk("t3_sack_end", {sack_n, busy}, 2'b10);
      end
    end
    chk("t3_grants", gcnt - g0, 2);

    // T4: no slave -> timeout
    start(1'b0, 1'b0, 16'o160000, 16'h0000);
    dcnt = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (!din_n) dcnt++;
      if (ack) seen = 1'b1;
    end
    chk("t4_ack", seen, 1'b1);
    chk("t4_err", err, 1'b1);
    chk("t4_din_cycles", dcnt, 64);
    chk("t4_rel", {sack_n, busy}, 2'b10);

    // T5: bus still busy after the grant
    ext_sync = 1'b1;
    start(1'b0, 1'b0, 16'o001000, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (!sack_n) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t5_grant", seen, 1'b1);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!sync_n || ad_oe) viol++;
    end
    chk("t5_hold", viol, 0);
    ext_sync = 1'b0;
    wait_ack(200, "t5_ack");
    chk("t5_rdata", rdata, 16'hABE5);

    // T6: INIT during the reply wait
    start(1'b0, 1'b0, 16'o160000, 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (!din_n) seen = 1'b1;
    end
    chk("t6_din", seen, 1'b1);
    repeat (3) @(posedge clk);
    #1 init_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_strobes", {sync_n, din_n, dout_n, wtbt_n, sack_n, dmr_n}, 6'h3F);
    chk("t6_oe_busy", {ad_oe, busy}, 2'b00);
    chk("t6_rdata_kept", rdata, 16'hABE5);
    init_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    chk("t6_no_ack", acks, 0);

    // Normal operation after the abort
    start(1'b0, 1'b0, 16'o001004, 16'h0000);
    wait_ack(200, "t7_ack");
    chk("t7_rdata", rdata, 16'h3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
